// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the MiniMIPS32 pipeline control block:
// stall bus width, stop/go levels, stage indices, FSM state encoding and
// the prefix-encoding helper used to build the stall bus.
package pipeline_ctrl_pkg;

    localparam int STALL_BUS = 5;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int STAGE_PC  = 0;
    localparam int STAGE_IF  = 1;
    localparam int STAGE_ID  = 2;
    localparam int STAGE_EXE = 3;
    localparam int STAGE_MEM = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_FLUSH = 2'b10
    } ctrl_state_e;

    // A stall raised by stage k freezes that stage and everything upstream of it.
    function automatic logic [STALL_BUS-1:0] stall_prefix(input int stage);
        logic [STALL_BUS-1:0] v;
        v = {STALL_BUS{NOSTOP}};
        for (int i = 0; i < STALL_BUS; i++) begin
            if (i <= stage) begin
                v[i] = STOP;
            end else begin
                v[i] = NOSTOP;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// Stall watchdog: counts consecutive cycles with the PC frozen and raises a
// sticky timeout flag once the count reaches WDOG_MAX. Only reset clears it.
module stall_watchdog #(
    parameter int WDOG_MAX = 1024,
    parameter int WDOG_W   = 11
) (
    input  logic cpu_clk_50M,
    input  logic cpu_rst,
    input  logic stall_pc,
    output logic stall_timeout
);

    localparam logic [WDOG_W-1:0] CNT_MAX  = WDOG_W'(WDOG_MAX);
    localparam logic [WDOG_W-1:0] CNT_ONE  = WDOG_W'(1);
    localparam logic [WDOG_W-1:0] CNT_ZERO = WDOG_W'(0);

    logic [WDOG_W-1:0] cnt_r;
    logic              timeout_r;

    // Consecutive-stall counter, saturating at WDOG_MAX, cleared when the PC moves.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            cnt_r <= CNT_ZERO;
        end else if (!stall_pc) begin
            cnt_r <= CNT_ZERO;
        end else if (cnt_r < CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky flag: set on the edge where the counter reaches WDOG_MAX.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            timeout_r <= 1'b0;
        end else if (stall_pc && (cnt_r >= (CNT_MAX - CNT_ONE))) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign stall_timeout = timeout_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage MiniMIPS32 pipeline.
// Merges stage stall requests into the prefix-encoded stall bus, waits for
// outstanding AXI transactions before flushing on an exception, and issues
// a single flush pulse together with the PC redirect.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WDOG_MAX = 1024,
    parameter int WDOG_W   = 11
) (
    input  logic                 cpu_clk_50M,
    input  logic                 cpu_rst,
    input  logic                 stallreq_if,
    input  logic                 stallreq_id,
    input  logic                 stallreq_exe,
    input  logic                 stallreq_mem,
    input  logic                 exc_req,
    input  logic [31:0]          exc_target,
    input  logic                 axi_inst_busy,
    input  logic                 axi_data_busy,
    output logic [STALL_BUS-1:0] stall,
    output logic                 flush,
    output logic                 redirect_en,
    output logic [31:0]          redirect_pc,
    output logic                 stall_timeout
);

    ctrl_state_e          state_r;
    ctrl_state_e          next_state_s;
    logic [STALL_BUS-1:0] stall_s;
    logic                 axi_busy_s;
    logic [31:0]          target_r;
    logic [31:0]          flush_pc_s;
    logic                 flush_r;
    logic                 redirect_en_r;
    logic [31:0]          redirect_pc_r;

    assign axi_busy_s = axi_inst_busy | axi_data_busy;

    // Next-state and stall-bus decode; the stall bus has no register stage.
    always_comb begin
        stall_s      = {STALL_BUS{NOSTOP}};
        next_state_s = state_r;
        flush_pc_s   = target_r;
        case (state_r)
            ST_RUN: begin
                if (stallreq_mem) begin
                    stall_s = stall_prefix(STAGE_MEM);
                end else if (stallreq_exe) begin
                    stall_s = stall_prefix(STAGE_EXE);
                end else if (stallreq_id) begin
                    stall_s = stall_prefix(STAGE_ID);
                end else if (stallreq_if) begin
                    stall_s = stall_prefix(STAGE_IF);
                end else begin
                    stall_s = {STALL_BUS{NOSTOP}};
                end
                // A direct RUN->FLUSH jump has not latched the target yet.
                flush_pc_s = exc_target;
                if (exc_req) begin
                    if (axi_busy_s) begin
                        next_state_s = ST_DRAIN;
                    end else begin
                        next_state_s = ST_FLUSH;
                    end
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                stall_s = {STALL_BUS{STOP}};
                if (!axi_busy_s) begin
                    next_state_s = ST_FLUSH;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                stall_s      = {STALL_BUS{NOSTOP}};
                next_state_s = ST_RUN;
            end
            default: begin
                stall_s      = {STALL_BUS{NOSTOP}};
                next_state_s = ST_RUN;
            end
        endcase
    end

    // State register.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the handler address when an exception is accepted in RUN;
    // later requests while draining must not overwrite it.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            target_r <= 32'h0000_0000;
        end else if ((state_r == ST_RUN) && exc_req) begin
            target_r <= exc_target;
        end else begin
            target_r <= target_r;
        end
    end

    // Registered flush pulse and redirect, asserted for the single FLUSH cycle.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            flush_r       <= 1'b0;
            redirect_en_r <= 1'b0;
            redirect_pc_r <= 32'h0000_0000;
        end else if (next_state_s == ST_FLUSH) begin
            flush_r       <= 1'b1;
            redirect_en_r <= 1'b1;
            redirect_pc_r <= flush_pc_s;
        end else begin
            flush_r       <= 1'b0;
            redirect_en_r <= 1'b0;
            redirect_pc_r <= redirect_pc_r;
        end
    end

    stall_watchdog #(
        .WDOG_MAX (WDOG_MAX),
        .WDOG_W   (WDOG_W)
    ) u_stall_watchdog (
        .cpu_clk_50M   (cpu_clk_50M),
        .cpu_rst       (cpu_rst),
        .stall_pc      (stall_s[STAGE_PC]),
        .stall_timeout (stall_timeout)
    );

    assign stall       = stall_s;
    assign flush       = flush_r;
    assign redirect_en = redirect_en_r;
    assign redirect_pc = redirect_pc_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations, plus a per-cycle comparison against a behavioural model.
module tb_pipeline_ctrl;

    localparam int TB_WDOG_MAX = 8;
    localparam int TB_WDOG_W   = 4;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_exe;
    logic        stallreq_mem;
    logic        exc_req;
    logic [31:0] exc_target;
    logic        axi_inst_busy;
    logic        axi_data_busy;
    logic [4:0]  stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        stall_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_ctrl #(
        .WDOG_MAX (TB_WDOG_MAX),
        .WDOG_W   (TB_WDOG_W)
    ) dut (
        .cpu_clk_50M   (clk),
        .cpu_rst       (rst),
        .stallreq_if   (stallreq_if),
        .stallreq_id   (stallreq_id),
        .stallreq_exe  (stallreq_exe),
        .stallreq_mem  (stallreq_mem),
        .exc_req       (exc_req),
        .exc_target    (exc_target),
        .axi_inst_busy (axi_inst_busy),
        .axi_data_busy (axi_data_busy),
        .stall         (stall),
        .flush         (flush),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .stall_timeout (stall_timeout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_drain: an exception is waiting for AXI to go quiet.
    // m_flush: this cycle is the flush/redirect cycle.
    logic        m_drain;
    logic        m_flush;
    logic [31:0] m_target;
    logic [31:0] m_rpc;
    int          m_cnt;
    logic        m_timeout;
    int          m_top;
    logic [4:0]  m_stall;

    // Expected stall bus: bits up to the highest requesting stage.
    always_comb begin
        m_top = -1;
        if (stallreq_if)  m_top = 1;
        if (stallreq_id)  m_top = 2;
        if (stallreq_exe) m_top = 3;
        if (stallreq_mem) m_top = 4;
        m_stall = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            if (i <= m_top) m_stall[i] = 1'b1;
        end
        if (m_drain) m_stall = 5'b11111;
        if (m_flush) m_stall = 5'b00000;
    end

    // Model state advance on each clock edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_drain   <= 1'b0;
            m_flush   <= 1'b0;
            m_target  <= 32'h0;
            m_rpc     <= 32'h0;
            m_cnt     <= 0;
            m_timeout <= 1'b0;
        end else begin
            m_flush <= 1'b0;
            if (m_flush) begin
                m_drain <= 1'b0;
            end else if (m_drain) begin
                if (!axi_inst_busy && !axi_data_busy) begin
                    m_flush <= 1'b1;
                    m_drain <= 1'b0;
                    m_rpc   <= m_target;
                end
            end else if (exc_req) begin
                m_target <= exc_target;
                if (axi_inst_busy || axi_data_busy) begin
                    m_drain <= 1'b1;
                end else begin
                    m_flush <= 1'b1;
                    m_rpc   <= exc_target;
                end
            end
            if (m_stall[0]) begin
                if (m_cnt < TB_WDOG_MAX) m_cnt <= m_cnt + 1;
                if (m_cnt + 1 >= TB_WDOG_MAX) m_timeout <= 1'b1;
            end else begin
                m_cnt <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("model_stall",       32'(stall),         32'(m_stall));
        chk("model_flush",       32'(flush),         32'(m_flush));
        chk("model_redirect_en", 32'(redirect_en),   32'(m_flush));
        chk("model_redirect_pc", redirect_pc,        m_rpc);
        chk("model_timeout",     32'(stall_timeout), 32'(m_timeout));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stallreq_if   = 1'b0;
        stallreq_id   = 1'b0;
        stallreq_exe  = 1'b0;
        stallreq_mem  = 1'b0;
        exc_req       = 1'b0;
        exc_target    = 32'h0;
        axi_inst_busy = 1'b0;
        axi_data_busy = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("reset_stall",       32'(stall),         32'h0);
        chk("reset_flush",       32'(flush),         32'h0);
        chk("reset_redirect_en", 32'(redirect_en),   32'h0);
        chk("reset_redirect_pc", redirect_pc,        32'h0);
        chk("reset_timeout",     32'(stall_timeout), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: EXE stall for exactly three cycles
        for (int i = 0; i < 3; i++) begin
            stallreq_exe = 1'b1;
            #1;
            chk("exe_stall", 32'(stall), 32'h0000_000F);
            chk("exe_flush", 32'(flush), 32'h0);
            tick();
        end
        stallreq_exe = 1'b0;
        #1 chk("exe_release", 32'(stall), 32'h0);
        tick();

        // 2: ID and MEM together, MEM wins
        stallreq_id  = 1'b1;
        stallreq_mem = 1'b1;
        #1 chk("id_mem_stall", 32'(stall), 32'h0000_001F);
        stallreq_mem = 1'b0;
        #1 chk("id_only_stall", 32'(stall), 32'h0000_0007);
        stallreq_id = 1'b0;
        stallreq_if = 1'b1;
        #1 chk("if_only_stall", 32'(stall), 32'h0000_0003);
        tick();
        stallreq_if = 1'b0;
        tick();

        // 3: exception with no AXI outstanding -> flush next cycle
        exc_req    = 1'b1;
        exc_target = 32'hBFC0_0380;
        #1;
        chk("exc_cycle_stall", 32'(stall), 32'h0);
        chk("exc_cycle_flush", 32'(flush), 32'h0);
        tick();
        exc_req      = 1'b0;
        exc_target   = 32'h0;
        stallreq_exe = 1'b1;
        #1;
        chk("flush_pulse",       32'(flush),       32'h1);
        chk("flush_redirect_en", 32'(redirect_en), 32'h1);
        chk("flush_redirect_pc", redirect_pc,      32'hBFC0_0380);
        chk("flush_stall_zero",  32'(stall),       32'h0);
        tick();
        stallreq_exe = 1'b0;
        #1;
        chk("after_flush_flush", 32'(flush),       32'h0);
        chk("after_flush_ren",   32'(redirect_en), 32'h0);
        tick();

        // 4: exception while data bus busy for four cycles
        exc_req       = 1'b1;
        exc_target    = 32'hBFC0_0380;
        axi_data_busy = 1'b1;
        #1 chk("drain_entry_stall", 32'(stall), 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            exc_req    = 1'b1;
            exc_target = 32'h0;
            #1;
            chk("drain_stall", 32'(stall), 32'h0000_001F);
            chk("drain_flush", 32'(flush), 32'h0);
            tick();
        end
        exc_req       = 1'b0;
        axi_data_busy = 1'b0;
        #1;
        chk("drain_last_stall", 32'(stall), 32'h0000_001F);
        chk("drain_last_flush", 32'(flush), 32'h0);
        tick();
        #1;
        chk("drain_flush_pulse", 32'(flush),  32'h1);
        chk("drain_redirect_pc", redirect_pc, 32'hBFC0_0380);
        chk("drain_flush_stall", 32'(stall),  32'h0);
        tick();
        chk("drain_done_flush", 32'(flush), 32'h0);
        tick();

        // 5: reset in the middle of a drain
        exc_req       = 1'b1;
        exc_target    = 32'h8000_0180;
        axi_inst_busy = 1'b1;
        tick();
        exc_req    = 1'b0;
        exc_target = 32'h0;
        tick();
        #1 chk("pre_reset_drain", 32'(stall), 32'h0000_001F);
        #2 rst = 1'b1;
        #1;
        chk("midrst_stall",       32'(stall),       32'h0);
        chk("midrst_flush",       32'(flush),       32'h0);
        chk("midrst_redirect_en", 32'(redirect_en), 32'h0);
        chk("midrst_redirect_pc", redirect_pc,      32'h0);
        tick();
        rst           = 1'b0;
        axi_inst_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_no_flush", 32'(flush), 32'h0);
            chk("postrst_no_stall", 32'(stall), 32'h0);
        end

        // 6: watchdog with WDOG_MAX = 8, IF stall held 10 cycles
        stallreq_if = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            #1 chk("wdog_stall", 32'(stall), 32'h0000_0003);
            @(posedge clk);
            #1;
            chk("wdog_timeout", 32'(stall_timeout), (i >= 8) ? 32'h1 : 32'h0);
        end
        stallreq_if = 1'b0;
        tick();
        chk("wdog_sticky", 32'(stall_timeout), 32'h1);
        tick();
        tick();
        chk("wdog_sticky_late", 32'(stall_timeout), 32'h1);
        #1 rst = 1'b1;
        #1 chk("wdog_cleared_by_reset", 32'(stall_timeout), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("wdog_stays_clear", 32'(stall_timeout), 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
